axi_lite_arb_nx1_ot: RTL and testbench

- Parametrised N-master to 1-slave AXI-Lite arbiter, next generation of the fixed 4-master bridge.
- Any N ≥ 2 with generate-based muxing.
- Up to MAX_OUTSTANDING address-accepted transactions in flight per direction, with response routing through per-direction order FIFOs of master indices.
- Selectable round-robin or fixed-priority arbitration.
- Sits between CPU/DMA masters and a shared AXI-Lite peripheral slave; adds zero cycles to address, data and response paths.

---
 rtl/axi_lite_arb_nx1_ot.sv | 251 +++++++++++++++++++++++++
 tb/tb_axi_lite_arb_nx1_ot.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arb_nx1_ot.sv
// axi_lite_arb_nx1_ot: N-master to 1-slave AXI-Lite arbiter with outstanding support.
//   AW and AR are arbitrated independently (round-robin or fixed priority).
//   Accepted transactions push the granted master index into order FIFOs.
//   W, B and R are steered by the FIFO heads, so these paths add no cycles.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   m_* (packed, slice i)   : master-side AXI-Lite channels for master i
//   s_*                     : shared slave-side AXI-Lite channels
//   wr_outstanding          : entries in the B order FIFO
//   rd_outstanding          : entries in the R order FIFO
//   resp_err                : sticky, slave response seen with no entry outstanding

// Small order FIFO of master indices.
module axi_lite_arb_nx1_ot_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 2,
  parameter int CNT_W = 3,
  parameter int PW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [DW-1:0]    i_din,
  input  logic             i_pop,
  output logic [DW-1:0]    o_head,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_empty,
  output logic             o_full
);
  logic [DW-1:0]    r_mem [DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push, w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  // Full is judged on the registered count: a pop in the same cycle does not free a slot.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rp];
  assign o_cnt   = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= (r_wp == PW'(DEPTH-1)) ? '0 : r_wp + 1'b1;
      end
      if (w_pop) r_rp <= (r_rp == PW'(DEPTH-1)) ? '0 : r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// Address-channel arbiter: picks a master, locks it while the slave stalls.
module axi_lite_arb_nx1_ot_arb #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int ARB_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_req,
  input  logic             i_ok,     // response FIFO has room
  input  logic             i_ready,  // slave-side ready
  output logic             o_valid,
  output logic [IDX_W-1:0] o_gnt
);
  logic [IDX_W-1:0] r_ptr, r_idx;
  logic             r_lock;
  logic [N-1:0]     w_elig;
  logic             w_found;
  logic [IDX_W-1:0] w_pick;
  int               w_j;

  assign w_elig = i_req & {N{i_ok}};

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_j     = 0;
    if (ARB_MODE == 0) begin
      for (int k = 0; k < N; k++) begin
        w_j = (int'(r_ptr) + k) % N;
        if (!w_found && w_elig[w_j]) begin
          w_found = 1'b1;
          w_pick  = IDX_W'(w_j);
        end
      end
    end else begin
      for (int k = N-1; k >= 0; k--) begin
        if (w_elig[k]) begin
          w_found = 1'b1;
          w_pick  = IDX_W'(k);
        end
      end
    end
  end

  // While locked the grant is frozen; nothing else can be pushed meanwhile,
  // so the FIFO room that admitted the request is still there.
  assign o_gnt   = r_lock ? r_idx : w_pick;
  assign o_valid = r_lock ? i_req[r_idx] : w_found;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_idx  <= '0;
      r_lock <= 1'b0;
    end else if (o_valid) begin
      if (i_ready) begin
        r_lock <= 1'b0;
        r_ptr  <= (o_gnt == IDX_W'(N-1)) ? '0 : o_gnt + 1'b1;
      end else begin
        r_lock <= 1'b1;
        r_idx  <= o_gnt;
      end
    end
  end
endmodule

module axi_lite_arb_nx1_ot #(
  parameter int N               = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = 0,
  parameter int IDX_W           = $clog2(N),
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING+1),
  localparam int PW             = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
  localparam int SW             = DATA_WIDTH/8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*ADDR_WIDTH-1:0] m_aw_addr,
  input  logic [N-1:0]            m_aw_valid,
  output logic [N-1:0]            m_aw_ready,
  input  logic [N*DATA_WIDTH-1:0] m_w_data,
  input  logic [N*SW-1:0]         m_w_strb,
  input  logic [N-1:0]            m_w_valid,
  output logic [N-1:0]            m_w_ready,
  output logic [2*N-1:0]          m_b_resp,
  output logic [N-1:0]            m_b_valid,
  input  logic [N-1:0]            m_b_ready,
  input  logic [N*ADDR_WIDTH-1:0] m_ar_addr,
  input  logic [N-1:0]            m_ar_valid,
  output logic [N-1:0]            m_ar_ready,
  output logic [N*DATA_WIDTH-1:0] m_r_data,
  output logic [2*N-1:0]          m_r_resp,
  output logic [N-1:0]            m_r_valid,
  input  logic [N-1:0]            m_r_ready,
  output logic [ADDR_WIDTH-1:0]   s_aw_addr,
  output logic                    s_aw_valid,
  input  logic                    s_aw_ready,
  output logic [DATA_WIDTH-1:0]   s_w_data,
  output logic [SW-1:0]           s_w_strb,
  output logic                    s_w_valid,
  input  logic                    s_w_ready,
  input  logic [1:0]              s_b_resp,
  input  logic                    s_b_valid,
  output logic                    s_b_ready,
  output logic [ADDR_WIDTH-1:0]   s_ar_addr,
  output logic                    s_ar_valid,
  input  logic                    s_ar_ready,
  input  logic [DATA_WIDTH-1:0]   s_r_data,
  input  logic [1:0]              s_r_resp,
  input  logic                    s_r_valid,
  output logic                    s_r_ready,
  output logic [CNT_W-1:0]        wr_outstanding,
  output logic [CNT_W-1:0]        rd_outstanding,
  output logic                    resp_err
);
  logic [IDX_W-1:0] w_aw_gnt, w_ar_gnt, w_wq_head, w_bq_head, w_rq_head;
  logic             w_wq_empty, w_bq_empty, w_rq_empty, w_bq_full, w_rq_full;
  logic             w_wq_full;
  logic [CNT_W-1:0] w_wq_cnt;
  logic             w_aw_hs, w_ar_hs, w_w_hs, w_b_hs, w_r_hs;
  logic             r_resp_err;

  axi_lite_arb_nx1_ot_arb #(.N(N), .IDX_W(IDX_W), .ARB_MODE(ARB_MODE)) u_aw_arb (
    .clk(clk), .rst(rst), .i_req(m_aw_valid), .i_ok(!w_bq_full), .i_ready(s_aw_ready),
    .o_valid(s_aw_valid), .o_gnt(w_aw_gnt));

  axi_lite_arb_nx1_ot_arb #(.N(N), .IDX_W(IDX_W), .ARB_MODE(ARB_MODE)) u_ar_arb (
    .clk(clk), .rst(rst), .i_req(m_ar_valid), .i_ok(!w_rq_full), .i_ready(s_ar_ready),
    .o_valid(s_ar_valid), .o_gnt(w_ar_gnt));

  assign w_aw_hs = s_aw_valid && s_aw_ready;
  assign w_ar_hs = s_ar_valid && s_ar_ready;
  assign w_w_hs  = s_w_valid && s_w_ready;
  assign w_b_hs  = s_b_valid && s_b_ready;
  assign w_r_hs  = s_r_valid && s_r_ready;

  // W entries never outnumber B entries (W retires before its B), so the
  // B-FIFO room check also covers the W-FIFO.
  axi_lite_arb_nx1_ot_fifo #(.DEPTH(MAX_OUTSTANDING), .DW(IDX_W), .CNT_W(CNT_W), .PW(PW)) u_wq (
    .clk(clk), .rst(rst), .i_push(w_aw_hs), .i_din(w_aw_gnt), .i_pop(w_w_hs),
    .o_head(w_wq_head), .o_cnt(w_wq_cnt), .o_empty(w_wq_empty), .o_full(w_wq_full));

  axi_lite_arb_nx1_ot_fifo #(.DEPTH(MAX_OUTSTANDING), .DW(IDX_W), .CNT_W(CNT_W), .PW(PW)) u_bq (
    .clk(clk), .rst(rst), .i_push(w_aw_hs), .i_din(w_aw_gnt), .i_pop(w_b_hs),
    .o_head(w_bq_head), .o_cnt(wr_outstanding), .o_empty(w_bq_empty), .o_full(w_bq_full));

  axi_lite_arb_nx1_ot_fifo #(.DEPTH(MAX_OUTSTANDING), .DW(IDX_W), .CNT_W(CNT_W), .PW(PW)) u_rq (
    .clk(clk), .rst(rst), .i_push(w_ar_hs), .i_din(w_ar_gnt), .i_pop(w_r_hs),
    .o_head(w_rq_head), .o_cnt(rd_outstanding), .o_empty(w_rq_empty), .o_full(w_rq_full));

  // Slave-side address/data muxes; zero when nothing is selected.
  assign s_aw_addr = s_aw_valid ? m_aw_addr[w_aw_gnt*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign s_ar_addr = s_ar_valid ? m_ar_addr[w_ar_gnt*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  // W follows the registered FIFO head, so W can never overtake its own AW.
  assign s_w_valid = !w_wq_empty && m_w_valid[w_wq_head];
  assign s_w_data  = w_wq_empty ? '0 : m_w_data[w_wq_head*DATA_WIDTH +: DATA_WIDTH];
  assign s_w_strb  = w_wq_empty ? '0 : m_w_strb[w_wq_head*SW +: SW];
  // Responses with no owner are refused and flagged.
  assign s_b_ready = !w_bq_empty && m_b_ready[w_bq_head];
  assign s_r_ready = !w_rq_empty && m_r_ready[w_rq_head];

  for (genvar gi = 0; gi < N; gi++) begin : g_m
    logic w_w_sel, w_b_sel, w_r_sel;
    assign w_w_sel = !w_wq_empty && (w_wq_head == IDX_W'(gi));
    assign w_b_sel = !w_bq_empty && (w_bq_head == IDX_W'(gi));
    assign w_r_sel = !w_rq_empty && (w_rq_head == IDX_W'(gi));
    assign m_aw_ready[gi] = s_aw_valid && (w_aw_gnt == IDX_W'(gi)) && s_aw_ready;
    assign m_ar_ready[gi] = s_ar_valid && (w_ar_gnt == IDX_W'(gi)) && s_ar_ready;
    assign m_w_ready[gi]  = w_w_sel && s_w_ready;
    assign m_b_valid[gi]  = w_b_sel && s_b_valid;
    assign m_b_resp[2*gi +: 2] = w_b_sel ? s_b_resp : 2'b00;
    assign m_r_valid[gi]  = w_r_sel && s_r_valid;
    assign m_r_resp[2*gi +: 2] = w_r_sel ? s_r_resp : 2'b00;
    assign m_r_data[gi*DATA_WIDTH +: DATA_WIDTH] = w_r_sel ? s_r_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_resp_err <= 1'b0;
    else if ((s_b_valid && w_bq_empty) || (s_r_valid && w_rq_empty)) r_resp_err <= 1'b1;
  end
  assign resp_err = r_resp_err;

  // W-FIFO occupancy/full are bookkeeping only; not exported.
  logic w_unused;
  assign w_unused = ^{w_wq_cnt, w_wq_full};
endmodule

// File: tb/tb_axi_lite_arb_nx1_ot.sv
module tb_axi_lite_arb_nx1_ot;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // round-robin DUT signals
  logic [127:0] m_aw_addr, m_w_data, m_ar_addr, m_r_data;
  logic [3:0]   m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
  logic [3:0]   m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [15:0]  m_w_strb;
  logic [7:0]   m_b_resp, m_r_resp;
  logic [31:0]  s_aw_addr, s_w_data, s_ar_addr, s_r_data;
  logic [3:0]   s_w_strb;
  logic         s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
  logic         s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, resp_err;
  logic [1:0]   s_b_resp, s_r_resp;
  logic [2:0]   wr_outstanding, rd_outstanding;

  // fixed-priority DUT signals
  logic [127:0] f_m_aw_addr, f_m_w_data, f_m_ar_addr, f_m_r_data;
  logic [3:0]   f_m_aw_valid, f_m_aw_ready, f_m_w_valid, f_m_w_ready, f_m_b_valid, f_m_b_ready;
  logic [3:0]   f_m_ar_valid, f_m_ar_ready, f_m_r_valid, f_m_r_ready;
  logic [15:0]  f_m_w_strb;
  logic [7:0]   f_m_b_resp, f_m_r_resp;
  logic [31:0]  f_s_aw_addr, f_s_w_data, f_s_ar_addr, f_s_r_data;
  logic [3:0]   f_s_w_strb;
  logic         f_s_aw_valid, f_s_aw_ready, f_s_w_valid, f_s_w_ready, f_s_b_valid, f_s_b_ready;
  logic         f_s_ar_valid, f_s_ar_ready, f_s_r_valid, f_s_r_ready, f_resp_err;
  logic [1:0]   f_s_b_resp, f_s_r_resp;
  logic [2:0]   f_wr_outstanding, f_rd_outstanding;

  axi_lite_arb_nx1_ot #(.N(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4), .ARB_MODE(0)) dut (
    .clk(clk), .rst(rst),
    .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding), .resp_err(resp_err));

  axi_lite_arb_nx1_ot #(.N(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m_aw_addr(f_m_aw_addr), .m_aw_valid(f_m_aw_valid), .m_aw_ready(f_m_aw_ready),
    .m_w_data(f_m_w_data), .m_w_strb(f_m_w_strb), .m_w_valid(f_m_w_valid), .m_w_ready(f_m_w_ready),
    .m_b_resp(f_m_b_resp), .m_b_valid(f_m_b_valid), .m_b_ready(f_m_b_ready),
    .m_ar_addr(f_m_ar_addr), .m_ar_valid(f_m_ar_valid), .m_ar_ready(f_m_ar_ready),
    .m_r_data(f_m_r_data), .m_r_resp(f_m_r_resp), .m_r_valid(f_m_r_valid), .m_r_ready(f_m_r_ready),
    .s_aw_addr(f_s_aw_addr), .s_aw_valid(f_s_aw_valid), .s_aw_ready(f_s_aw_ready),
    .s_w_data(f_s_w_data), .s_w_strb(f_s_w_strb), .s_w_valid(f_s_w_valid), .s_w_ready(f_s_w_ready),
    .s_b_resp(f_s_b_resp), .s_b_valid(f_s_b_valid), .s_b_ready(f_s_b_ready),
    .s_ar_addr(f_s_ar_addr), .s_ar_valid(f_s_ar_valid), .s_ar_ready(f_s_ar_ready),
    .s_r_data(f_s_r_data), .s_r_resp(f_s_r_resp), .s_r_valid(f_s_r_valid), .s_r_ready(f_s_r_ready),
    .wr_outstanding(f_wr_outstanding), .rd_outstanding(f_rd_outstanding), .resp_err(f_resp_err));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  // advance one clock; returns at the following negedge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [4];
    order = '{1, 2, 3, 0};
    rst = 1'b1;
    {m_aw_addr, m_w_data, m_ar_addr, m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready, m_w_strb} = '0;
    {s_aw_ready, s_w_ready, s_b_valid, s_b_resp, s_ar_ready, s_r_valid, s_r_resp, s_r_data} = '0;
    {f_m_aw_addr, f_m_w_data, f_m_ar_addr, f_m_aw_valid, f_m_w_valid, f_m_b_ready, f_m_ar_valid, f_m_r_ready, f_m_w_strb} = '0;
    {f_s_aw_ready, f_s_w_ready, f_s_b_valid, f_s_b_resp, f_s_ar_ready, f_s_r_valid, f_s_r_resp, f_s_r_data} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wr_out", wr_outstanding, 0);
    chk("rst_rd_out", rd_outstanding, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_valids", {s_aw_valid, s_w_valid, s_ar_valid, s_b_ready, s_r_ready}, 0);
    chk("rst_mready", {m_aw_ready, m_w_ready, m_ar_ready, m_b_valid, m_r_valid}, 0);
    chk("rst_data", {s_aw_addr, s_ar_addr}, 0);

    // round-robin: all four request at once, slave always ready
    for (int i = 0; i < 4; i++) m_aw_addr[i*32 +: 32] = 32'h100 + i*16;
    m_aw_valid = 4'hF;
    s_aw_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_aw_addr", s_aw_addr, 32'h100 + k*16);
      chk("rr_aw_ready", m_aw_ready, 4'b1 << k);
      cyc();
      m_aw_valid[k] = 1'b0;
      #1 chk("rr_wr_out", wr_outstanding, k+1);
    end
    m_aw_addr[31:0] = 32'h200;
    m_aw_valid = 4'b0001;
    #1;
    chk("full_aw_valid", s_aw_valid, 0);
    chk("full_aw_ready", m_aw_ready, 0);

    // W in AW order
    for (int i = 0; i < 4; i++) m_w_data[i*32 +: 32] = 32'hA0 + i;
    m_w_strb = 16'hFFFF;
    m_w_valid = 4'hF;
    s_w_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("w_data", s_w_data, 32'hA0 + k);
      chk("w_ready", m_w_ready, 4'b1 << k);
      cyc();
      m_w_valid[k] = 1'b0;
    end
    #1;
    chk("w_done", s_w_valid, 0);
    chk("w_wr_out", wr_outstanding, 4);

    // first B: same-cycle pop must not free a slot for the stalled AW
    s_b_valid = 1'b1;
    s_b_resp  = 2'b00;
    m_b_ready = 4'hF;
    #1;
    chk("b0_valid", m_b_valid, 4'b0001);
    chk("b0_sready", s_b_ready, 1);
    chk("b0_aw_stall", s_aw_valid, 0);
    cyc();
    s_b_valid = 1'b0;
    #1;
    chk("b0_wr_out", wr_outstanding, 3);
    chk("aw_resume", {s_aw_valid, s_aw_addr}, {1'b1, 32'h200});
    cyc();
    m_aw_valid = 4'b0;
    #1 chk("aw_refill", wr_outstanding, 4);
    s_b_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("b_order", m_b_valid, 4'b1 << order[k]);
      cyc();
    end
    s_b_valid = 1'b0;
    #1 chk("b_drain", wr_outstanding, 0);
    m_w_valid = 4'b0001;
    cyc();
    m_w_valid = 4'b0;
    #1 chk("w_drain", s_w_valid, 0);

    // lock: slave stalls master 0, master 1 joins but must wait
    s_aw_ready = 1'b0;
    m_aw_addr[31:0]  = 32'h300;
    m_aw_addr[63:32] = 32'h310;
    m_aw_valid = 4'b0001;
    #1 chk("lock_addr0", s_aw_addr, 32'h300);
    cyc();
    m_aw_valid = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("lock_hold", {s_aw_valid, s_aw_addr}, {1'b1, 32'h300});
      chk("lock_rdy", m_aw_ready, 0);
      cyc();
    end
    s_aw_ready = 1'b1;
    #1 chk("lock_hs", {m_aw_ready, s_aw_addr}, {4'b0001, 32'h300});
    cyc();
    m_aw_valid = 4'b0010;
    #1 chk("lock_next", {m_aw_ready, s_aw_addr}, {4'b0010, 32'h310});
    cyc();
    m_aw_valid = 4'b0;
    #1 chk("lock_wr_out", wr_outstanding, 2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1 chk("rst2", {wr_outstanding, s_w_valid}, 0);

    // masters 1 then 3 write; W of 3 waits for W of 1; B OKAY then SLVERR
    m_w_data[63:32]  = 32'h11;
    m_w_data[127:96] = 32'h33;
    m_w_valid  = 4'b1010;
    m_aw_valid = 4'b0010;
    #1;
    chk("ord_aw1", m_aw_ready, 4'b0010);
    chk("ord_w_early", {m_w_ready, s_w_valid}, 0);
    cyc();
    m_aw_valid = 4'b1000;
    #1;
    chk("ord_aw3", m_aw_ready, 4'b1000);
    chk("ord_w1", {m_w_ready, s_w_data}, {4'b0010, 32'h11});
    cyc();
    m_aw_valid = 4'b0;
    m_w_valid  = 4'b1000;
    #1 chk("ord_w3", {m_w_ready, s_w_data}, {4'b1000, 32'h33});
    cyc();
    m_w_valid = 4'b0;
    s_b_valid = 1'b1;
    s_b_resp  = 2'b00;
    m_b_ready = 4'b1010;
    #1 chk("ord_b1", {m_b_valid, m_b_resp}, {4'b0010, 8'h00});
    cyc();
    s_b_resp = 2'b10;
    #1 chk("ord_b3", {m_b_valid, m_b_resp}, {4'b1000, 8'h80});
    cyc();
    s_b_valid = 1'b0;
    #1 chk("ord_wr_out", wr_outstanding, 0);

    // reads: fill to MAX_OUTSTANDING, reset, then a fresh AR
    s_ar_ready = 1'b1;
    m_ar_addr[31:0]  = 32'h400;
    m_ar_addr[95:64] = 32'h420;
    m_ar_valid = 4'b0001;
    repeat (4) cyc();
    #1 chk("rd_full", {rd_outstanding, s_ar_valid}, {3'd4, 1'b0});
    m_ar_valid = 4'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1 chk("rd_rst", {rd_outstanding, s_ar_valid}, 0);
    m_ar_valid = 4'b0100;
    #1 chk("rd_new", {s_ar_valid, s_ar_addr, m_ar_ready}, {1'b1, 32'h420, 4'b0100});
    cyc();
    m_ar_valid = 4'b0;
    #1 chk("rd_out1", rd_outstanding, 1);
    s_r_valid = 1'b1;
    s_r_data  = 32'hDEAD;
    m_r_ready = 4'b0100;
    #1;
    chk("r_route", {m_r_valid, s_r_ready}, {4'b0100, 1'b1});
    chk("r_data", m_r_data, {32'h0, 32'hDEAD, 32'h0, 32'h0});
    cyc();
    s_r_valid = 1'b0;
    #1 chk("r_done", rd_outstanding, 0);

    // orphan R response
    s_r_valid = 1'b1;
    m_r_ready = 4'hF;
    #1 chk("err_ready", {s_r_ready, resp_err}, 0);
    cyc();
    s_r_valid = 1'b0;
    #1 chk("err_set", resp_err, 1);
    repeat (2) cyc();
    #1 chk("err_sticky", resp_err, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1 chk("err_clr", resp_err, 0);

    // fixed priority: 2 and 3 request continuously, 2 always wins
    f_s_ar_ready = 1'b1;
    f_m_r_ready  = 4'hF;
    f_m_ar_addr[95:64]  = 32'h520;
    f_m_ar_addr[127:96] = 32'h530;
    f_m_ar_valid = 4'b1100;
    for (int k = 0; k < 3; k++) begin
      #1 chk("fp_win", {f_m_ar_ready, f_s_ar_addr}, {4'b0100, 32'h520});
      cyc();
      f_s_r_valid = 1'b1;
    end
    #1 chk("fp_state", {f_rd_outstanding, f_resp_err, f_m_r_valid}, {3'd1, 1'b0, 4'b0100});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
